l1_wishbone_arbiter: RTL and testbench

L1_WISHBONE_ARBITER -- requirements
Module: l1_wishbone_arbiter

---
 rtl/l1_wishbone_arbiter_if.sv | 47 ++++
 rtl/l1_wishbone_arbiter.sv | 161 ++++++++++++++++
 tb/tb_l1_wishbone_arbiter.sv | 472 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/l1_wishbone_arbiter_if.sv
// Bus bundles shared between the L1 caches, the arbiter and the Wishbone fabric.

// Per-requester request channel (cache -> arbiter).
interface l1_arbiter_request_interface;
    logic [31:0] addr;
    logic [31:0] data;
    logic        rnw;
    logic [3:0]  be;
    logic [4:0]  size;
    logic        is_amo;
    logic [4:0]  amo;
    logic        request;
    logic        ack;

    modport master (output addr, data, rnw, be, size, is_amo, amo, request, input ack);
    modport slave  (input addr, data, rnw, be, size, is_amo, amo, request, output ack);
endinterface

// Per-requester return channel (arbiter -> cache).
interface l1_arbiter_return_interface;
    logic [31:0] data;
    logic        data_valid;
    logic [31:0] inv_addr;
    logic        inv_valid;
    logic        inv_ack;

    modport master (input data, data_valid, inv_addr, inv_valid, output inv_ack);
    modport slave  (output data, data_valid, inv_addr, inv_valid, input inv_ack);
endinterface

// Classic Wishbone B4 master/slave bundle with 30-bit word address.
interface wishbone_interface;
    logic [29:0] adr;
    logic [31:0] dat_w;
    logic [31:0] dat_r;
    logic [3:0]  sel;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic        ack;
    logic        err;

    modport master (output adr, dat_w, sel, cyc, stb, we, cti, bte, input dat_r, ack, err);
    modport slave  (input adr, dat_w, sel, cyc, stb, we, cti, bte, output dat_r, ack, err);
endinterface

// File: rtl/l1_wishbone_arbiter.sv
// Round-robin arbiter that funnels L1 cache requests onto one Wishbone bus.
// Reads may burst up to 32 words; writes are always a single beat.
module l1_wishbone_arbiter #(
    parameter int NUM_PORTS = 2
) (
    input  logic                              clk,
    input  logic                              rst_n,
    l1_arbiter_request_interface.slave        l1_request  [NUM_PORTS],
    l1_arbiter_return_interface.slave         l1_response [NUM_PORTS],
    wishbone_interface.master                 wishbone,
    output logic                              bus_error
);

    localparam int unsigned IDX_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int unsigned BEAT_W = 6;
    localparam int unsigned ADR_W  = 30;

    typedef enum logic {
        IDLE = 1'b0,
        BUS  = 1'b1
    } state_t;

    state_t              state_q;
    logic [IDX_W-1:0]    last_grant_q;
    logic [IDX_W-1:0]    grant_q;
    logic [ADR_W-1:0]    adr_q;
    logic [31:0]         dat_q;
    logic [3:0]          sel_q;
    logic                rnw_q;
    logic                burst_q;
    logic [BEAT_W-1:0]   beats_q;
    logic                bus_error_q;

    // Flattened view of the request interfaces for indexed access.
    logic [NUM_PORTS-1:0] req_v;
    logic [ADR_W-1:0]     req_adr  [NUM_PORTS];
    logic [31:0]          req_dat  [NUM_PORTS];
    logic [3:0]           req_be   [NUM_PORTS];
    logic                 req_rnw  [NUM_PORTS];
    logic [4:0]           req_size [NUM_PORTS];

    logic                 pick_valid;
    logic [IDX_W-1:0]     pick_idx;
    logic [ADR_W-1:0]     pick_adr;
    logic [31:0]          pick_dat;
    logic [3:0]           pick_be;
    logic                 pick_rnw;
    logic [4:0]           pick_size;

    logic                 in_bus;
    logic                 beat_done_c;

    assign in_bus      = (state_q == BUS);
    assign beat_done_c = in_bus && (wishbone.ack || wishbone.err);

    // Per-port wiring: request fan-in, ack, read return and the unused invalidation path.
    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
        logic unused_port;

        assign req_v[i]    = l1_request[i].request;
        assign req_adr[i]  = l1_request[i].addr[31:2];
        assign req_dat[i]  = l1_request[i].data;
        assign req_be[i]   = l1_request[i].be;
        assign req_rnw[i]  = l1_request[i].rnw;
        assign req_size[i] = l1_request[i].size;

        assign l1_request[i].ack = (state_q == IDLE) && pick_valid && (pick_idx == IDX_W'(i));

        assign l1_response[i].data       = wishbone.dat_r;
        assign l1_response[i].data_valid = beat_done_c && rnw_q && (grant_q == IDX_W'(i));
        assign l1_response[i].inv_addr   = 32'h0;
        assign l1_response[i].inv_valid  = 1'b0;

        // AMO fields, byte offset and invalidation ack carry no meaning here.
        assign unused_port = ^{l1_request[i].addr[1:0], l1_request[i].is_amo,
                               l1_request[i].amo, l1_response[i].inv_ack};
    end

    // Round-robin pick: scan ports starting one past the last winner.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        pick_adr   = '0;
        pick_dat   = '0;
        pick_be    = '0;
        pick_rnw   = 1'b0;
        pick_size  = '0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            for (int j = 0; j < NUM_PORTS; j++) begin
                if (!pick_valid && req_v[j] && (j == (int'(last_grant_q) + k) % NUM_PORTS)) begin
                    pick_valid = 1'b1;
                    pick_idx   = IDX_W'(j);
                    pick_adr   = req_adr[j];
                    pick_dat   = req_dat[j];
                    pick_be    = req_be[j];
                    pick_rnw   = req_rnw[j];
                    pick_size  = req_size[j];
                end
            end
        end
    end

    // Arbitration/transfer FSM with latched transaction and sticky error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= IDX_W'(NUM_PORTS - 1);
            grant_q      <= '0;
            adr_q        <= '0;
            dat_q        <= '0;
            sel_q        <= '0;
            rnw_q        <= 1'b0;
            burst_q      <= 1'b0;
            beats_q      <= '0;
            bus_error_q  <= 1'b0;
        end else begin
            if (wishbone.err) begin
                bus_error_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (pick_valid) begin
                        grant_q      <= pick_idx;
                        last_grant_q <= pick_idx;
                        adr_q        <= pick_adr;
                        dat_q        <= pick_dat;
                        sel_q        <= pick_rnw ? 4'hF : pick_be;
                        rnw_q        <= pick_rnw;
                        burst_q      <= pick_rnw && (pick_size != 5'd0);
                        beats_q      <= pick_rnw ? (BEAT_W'(pick_size) + BEAT_W'(1)) : BEAT_W'(1);
                        state_q      <= BUS;
                    end
                end
                BUS: begin
                    if (beat_done_c) begin
                        adr_q   <= adr_q + ADR_W'(1);
                        beats_q <= beats_q - BEAT_W'(1);
                        if (beats_q == BEAT_W'(1)) begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Bus outputs are pure functions of registered state.
    assign wishbone.cyc   = in_bus;
    assign wishbone.stb   = in_bus;
    assign wishbone.adr   = adr_q;
    assign wishbone.dat_w = dat_q;
    assign wishbone.we    = in_bus && !rnw_q;
    assign wishbone.sel   = in_bus ? sel_q : 4'h0;
    assign wishbone.bte   = 2'b00;
    assign wishbone.cti   = (!in_bus || !burst_q)    ? 3'b000 :
                            (beats_q == BEAT_W'(1))  ? 3'b111 : 3'b010;

    assign bus_error = bus_error_q;

endmodule

// File: tb/tb_l1_wishbone_arbiter.sv
// Scoreboard bench: requester/slave models drive the arbiter, a negedge monitor
// checks grants, bus beats and read returns against bench-computed expectations.
module tb_l1_wishbone_arbiter;

    localparam int NP = 2;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic        rnw;
        logic [3:0]  be;
        logic [4:0]  size;
    } req_t;

    typedef struct packed {
        logic [29:0] adr;
        logic [2:0]  cti;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] dat_w;
    } beat_t;

    typedef struct packed {
        logic [31:0] port;
        logic [31:0] data;
    } dv_t;

    logic clk;
    logic rst_n;
    logic bus_error;

    l1_arbiter_request_interface req_if [NP] ();
    l1_arbiter_return_interface  rsp_if [NP] ();
    wishbone_interface           wb ();

    l1_wishbone_arbiter #(.NUM_PORTS(NP)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .l1_request  (req_if),
        .l1_response (rsp_if),
        .wishbone    (wb),
        .bus_error   (bus_error)
    );

    logic [NP-1:0] t_req;
    logic [31:0]   t_addr  [NP];
    logic [31:0]   t_data  [NP];
    logic          t_rnw   [NP];
    logic [3:0]    t_be    [NP];
    logic [4:0]    t_size  [NP];
    logic [NP-1:0] t_ack;
    logic [NP-1:0] t_dv;
    logic [31:0]   t_rdata [NP];
    logic          t_invv  [NP];
    logic [31:0]   t_inva  [NP];

    logic        wb_ack;
    logic        wb_err;
    logic [31:0] wb_dat_r;
    int          wb_wait;
    int          err_beat;
    int          wcnt;
    int          bidx;

    req_t  rq0 [$];
    req_t  rq1 [$];
    beat_t exp_beats [$];
    dv_t   exp_dv [$];
    int    exp_grant [$];

    logic [NP-1:0] ack_seen;
    int    n_cmp;
    int    n_bad;
    int    cycle;
    int    dv_cnt [NP];
    logic  gap_due;
    logic  prev_cyc;
    int    last_ack_cyc;
    int    lat_dv;
    int    lat_cyc;
    logic  arm_dv;
    logic  arm_cyc;

    localparam logic [31:0] SALT = 32'hDEADBEEF ^ 32'h0000_1000;

    function automatic logic [31:0] data_fn(input logic [29:0] a);
        return {a, 2'b00} ^ SALT;
    endfunction

    for (genvar i = 0; i < NP; i++) begin : g_if
        assign req_if[i].request = t_req[i];
        assign req_if[i].addr    = t_addr[i];
        assign req_if[i].data    = t_data[i];
        assign req_if[i].rnw     = t_rnw[i];
        assign req_if[i].be      = t_be[i];
        assign req_if[i].size    = t_size[i];
        assign req_if[i].is_amo  = 1'b1;
        assign req_if[i].amo     = 5'h1F;
        assign t_ack[i]          = req_if[i].ack;
        assign t_dv[i]           = rsp_if[i].data_valid;
        assign t_rdata[i]        = rsp_if[i].data;
        assign t_invv[i]         = rsp_if[i].inv_valid;
        assign t_inva[i]         = rsp_if[i].inv_addr;
        assign rsp_if[i].inv_ack = 1'b1;
    end

    assign wb.ack   = wb_ack;
    assign wb.err   = wb_err;
    assign wb.dat_r = wb_dat_r;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle++;

    // Wishbone slave: waits wb_wait cycles per beat, errs on beat index err_beat.
    always @(posedge clk) begin
        #1;
        wb_ack = 1'b0;
        wb_err = 1'b0;
        if (wb.cyc && wb.stb) begin
            if (wcnt >= wb_wait) begin
                wcnt = 0;
                if (bidx == err_beat) wb_err = 1'b1;
                else                  wb_ack = 1'b1;
                wb_dat_r = data_fn(wb.adr);
                bidx++;
            end else begin
                wcnt++;
            end
        end else begin
            wcnt = 0;
            bidx = 0;
        end
    end

    // Requesters: hold the queue head until it is acked.
    always @(posedge clk) begin
        #1;
        if (ack_seen[0] && rq0.size() > 0) void'(rq0.pop_front());
        if (ack_seen[1] && rq1.size() > 0) void'(rq1.pop_front());
        ack_seen = '0;
        t_req[0] = (rq0.size() > 0);
        if (rq0.size() > 0) begin
            t_addr[0] = rq0[0].addr; t_data[0] = rq0[0].data; t_rnw[0] = rq0[0].rnw;
            t_be[0]   = rq0[0].be;   t_size[0] = rq0[0].size;
        end
        t_req[1] = (rq1.size() > 0);
        if (rq1.size() > 0) begin
            t_addr[1] = rq1[0].addr; t_data[1] = rq1[0].data; t_rnw[1] = rq1[0].rnw;
            t_be[1]   = rq1[0].be;   t_size[1] = rq1[0].size;
        end
    end

    // Monitor: grants, beats and read returns against the scoreboard.
    always @(negedge clk) begin
        int    p;
        int    e;
        beat_t b;
        dv_t   d;
        if (!rst_n) begin
            gap_due  = 1'b0;
            prev_cyc = 1'b0;
        end else begin
            if (gap_due) begin
                n_cmp++;
                if (wb.cyc !== 1'b0) begin
                    n_bad++; $display("FAIL cyc_gap: cyc=%b expected 0 after final beat", wb.cyc);
                end
                gap_due = 1'b0;
            end
            if (t_ack != '0) begin
                n_cmp++;
                if (wb.cyc !== 1'b0) begin
                    n_bad++; $display("FAIL ack_in_bus: ack=%b while cyc=%b", t_ack, wb.cyc);
                end
                n_cmp++;
                if ($countones(t_ack) != 1) begin
                    n_bad++; $display("FAIL ack_onehot: ack=%b expected one-hot", t_ack);
                end else begin
                    p = 0;
                    for (int i = 0; i < NP; i++) if (t_ack[i]) p = i;
                    ack_seen[p]  = 1'b1;
                    last_ack_cyc = cycle;
                    arm_dv       = 1'b1;
                    arm_cyc      = 1'b1;
                    n_cmp++;
                    if (exp_grant.size() == 0) begin
                        n_bad++; $display("FAIL unexpected_grant: port %0d acked, none expected", p);
                    end else begin
                        e = exp_grant.pop_front();
                        if (p != e) begin
                            n_bad++; $display("FAIL grant: got port %0d expected port %0d", p, e);
                        end
                    end
                    if (t_rnw[p]) begin
                        for (int k = 0; k <= int'(t_size[p]); k++) begin
                            b.adr   = t_addr[p][31:2] + 30'(k);
                            b.cti   = (t_size[p] == 5'd0) ? 3'b000 :
                                      (k == int'(t_size[p])) ? 3'b111 : 3'b010;
                            b.we    = 1'b0;
                            b.sel   = 4'hF;
                            b.dat_w = t_data[p];
                            exp_beats.push_back(b);
                            d.port = 32'(p);
                            d.data = data_fn(b.adr);
                            exp_dv.push_back(d);
                        end
                    end else begin
                        b.adr   = t_addr[p][31:2];
                        b.cti   = 3'b000;
                        b.we    = 1'b1;
                        b.sel   = t_be[p];
                        b.dat_w = t_data[p];
                        exp_beats.push_back(b);
                    end
                end
            end
            if (wb.cyc) begin
                if (!prev_cyc && arm_cyc) begin
                    lat_cyc = cycle - last_ack_cyc;
                    arm_cyc = 1'b0;
                end
                n_cmp++;
                if (exp_beats.size() == 0) begin
                    n_bad++; $display("FAIL unexpected_cyc: cyc=1 adr=%h with no beat expected", wb.adr);
                end else begin
                    b = exp_beats[0];
                    if ({wb.stb, wb.adr, wb.cti, wb.we, wb.sel, wb.dat_w, wb.bte} !==
                        {1'b1, b.adr, b.cti, b.we, b.sel, b.dat_w, 2'b00}) begin
                        n_bad++;
                        $display("FAIL beat: got stb=%b adr=%h cti=%b we=%b sel=%h dat_w=%h bte=%b expected stb=1 adr=%h cti=%b we=%b sel=%h dat_w=%h bte=00",
                                 wb.stb, wb.adr, wb.cti, wb.we, wb.sel, wb.dat_w, wb.bte,
                                 b.adr, b.cti, b.we, b.sel, b.dat_w);
                    end
                    if (wb_ack || wb_err) begin
                        void'(exp_beats.pop_front());
                        if (exp_beats.size() == 0) gap_due = 1'b1;
                    end
                end
            end
            for (int i = 0; i < NP; i++) begin
                if (t_dv[i]) begin
                    dv_cnt[i]++;
                    if (arm_dv) begin
                        lat_dv = cycle - last_ack_cyc;
                        arm_dv = 1'b0;
                    end
                    n_cmp++;
                    if (!(wb_ack || wb_err)) begin
                        n_bad++; $display("FAIL dv_no_ack: data_valid on port %0d without ack/err", i);
                    end
                    n_cmp++;
                    if (exp_dv.size() == 0) begin
                        n_bad++; $display("FAIL unexpected_dv: port %0d data %h", i, t_rdata[i]);
                    end else begin
                        d = exp_dv.pop_front();
                        if (d.port != 32'(i) || t_rdata[i] !== d.data) begin
                            n_bad++;
                            $display("FAIL dv: got port %0d data %h expected port %0d data %h",
                                     i, t_rdata[i], d.port, d.data);
                        end
                    end
                end
            end
            prev_cyc = wb.cyc;
        end
    end

    task automatic clear_all();
        rq0.delete(); rq1.delete();
        exp_beats.delete(); exp_dv.delete(); exp_grant.delete();
        ack_seen = '0;
        arm_dv   = 1'b0;
        arm_cyc  = 1'b0;
    endtask

    task automatic assert_reset();
        @(posedge clk); #2;
        rst_n = 1'b0;
        clear_all();
    endtask

    task automatic release_reset();
        @(posedge clk); #3;
        rst_n = 1'b1;
    endtask

    task automatic push_req(input int port, input logic [31:0] addr, input logic [31:0] data,
                            input logic rnw, input logic [3:0] be, input logic [4:0] size);
        req_t r;
        r.addr = addr; r.data = data; r.rnw = rnw; r.be = be; r.size = size;
        if (port == 0) rq0.push_back(r);
        else           rq1.push_back(r);
        exp_grant.push_back(port);
    endtask

    task automatic wait_done(input string name, input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk); #2;
            n++;
        end while (n < budget && (rq0.size() != 0 || rq1.size() != 0 || exp_beats.size() != 0 ||
                   exp_dv.size() != 0 || exp_grant.size() != 0 || wb.cyc));
        n_cmp++;
        if (n >= budget) begin
            n_bad++;
            $display("FAIL timeout_%s: pending grants=%0d beats=%0d dv=%0d after %0d cycles, expected 0",
                     name, exp_grant.size(), exp_beats.size(), exp_dv.size(), n);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        n_cmp++; if ({wb.cyc, wb.stb, wb.we} !== 3'b000) begin
            n_bad++; $display("FAIL reset_cyc_stb_we: got %b expected 000", {wb.cyc, wb.stb, wb.we}); end
        n_cmp++; if (wb.cti !== 3'b000) begin
            n_bad++; $display("FAIL reset_cti: got %b expected 000", wb.cti); end
        n_cmp++; if (wb.sel !== 4'h0) begin
            n_bad++; $display("FAIL reset_sel: got %h expected 0", wb.sel); end
        n_cmp++; if ({t_ack, t_dv} !== '0) begin
            n_bad++; $display("FAIL reset_ack_dv: got ack=%b dv=%b expected 0", t_ack, t_dv); end
        n_cmp++; if (bus_error !== 1'b0) begin
            n_bad++; $display("FAIL reset_bus_error: got %b expected 0", bus_error); end
        for (int i = 0; i < NP; i++) begin
            n_cmp++; if (t_invv[i] !== 1'b0 || t_inva[i] !== 32'h0) begin
                n_bad++; $display("FAIL reset_inv: port %0d inv_valid=%b inv_addr=%h expected 0/0", i, t_invv[i], t_inva[i]); end
        end
        release_reset();
        @(negedge clk); #1;
        n_cmp++; if (wb.cyc !== 1'b0 || bus_error !== 1'b0) begin
            n_bad++; $display("FAIL idle_after_reset: cyc=%b bus_error=%b expected 0/0", wb.cyc, bus_error); end
    endtask

    task automatic test_single_read();
        wb_wait = 1; err_beat = -1;
        push_req(0, 32'h0000_1000, 32'h0, 1'b1, 4'h0, 5'd0);
        wait_done("single_read", 40);
        n_cmp++; if (dv_cnt[0] != 1 || dv_cnt[1] != 0) begin
            n_bad++; $display("FAIL single_read_dv_count: got %0d/%0d expected 1/0", dv_cnt[0], dv_cnt[1]); end
    endtask

    task automatic test_latency();
        wb_wait = 0; err_beat = -1;
        push_req(1, 32'h0000_0440, 32'h0, 1'b1, 4'h0, 5'd0);
        wait_done("latency", 40);
        n_cmp++; if (lat_cyc != 1) begin
            n_bad++; $display("FAIL latency_cyc: got %0d cycles ack->cyc expected 1", lat_cyc); end
        n_cmp++; if (lat_dv != 1) begin
            n_bad++; $display("FAIL latency_dv: got %0d cycles ack->data_valid expected 1", lat_dv); end
    endtask

    task automatic test_burst();
        int d0, d1;
        wb_wait = 0; err_beat = -1;
        d0 = dv_cnt[0]; d1 = dv_cnt[1];
        push_req(1, 32'h0000_2000, 32'h0, 1'b1, 4'h0, 5'd7);
        wait_done("burst", 60);
        n_cmp++; if (dv_cnt[1] - d1 != 8 || dv_cnt[0] != d0) begin
            n_bad++; $display("FAIL burst_dv_count: got p1=%0d p0=%0d expected 8/0", dv_cnt[1] - d1, dv_cnt[0] - d0); end
        n_cmp++; if (t_invv[1] !== 1'b0 || t_inva[1] !== 32'h0) begin
            n_bad++; $display("FAIL burst_inv: inv_valid=%b inv_addr=%h expected 0/0", t_invv[1], t_inva[1]); end
    endtask

    task automatic test_write();
        int d0, d1;
        wb_wait = 1; err_beat = -1;
        d0 = dv_cnt[0]; d1 = dv_cnt[1];
        push_req(0, 32'h0000_3004, 32'h1234_5678, 1'b0, 4'b0011, 5'd5);
        wait_done("write", 40);
        n_cmp++; if (dv_cnt[0] != d0 || dv_cnt[1] != d1) begin
            n_bad++; $display("FAIL write_no_dv: got %0d data_valid pulses expected 0", dv_cnt[0] - d0 + dv_cnt[1] - d1); end
    endtask

    task automatic test_wrap();
        wb_wait = 0; err_beat = -1;
        push_req(0, 32'hFFFF_FFF8, 32'h0, 1'b1, 4'h0, 5'd3);
        wait_done("wrap", 40);
        n_cmp++; if (bus_error !== 1'b0) begin
            n_bad++; $display("FAIL wrap_bus_error: got %b expected 0", bus_error); end
    endtask

    task automatic test_contention();
        wb_wait = 0; err_beat = -1;
        assert_reset();
        for (int n = 0; n < 3; n++) begin
            push_req(0, 32'h0000_4000 + 32'(n * 4), 32'hA000_0000 + 32'(n), 1'b0, 4'hF, 5'd0);
            push_req(1, 32'h0000_8000 + 32'(n * 4), 32'h0, 1'b1, 4'h0, 5'd1);
        end
        release_reset();
        wait_done("contention", 80);
    endtask

    task automatic test_error();
        int d0;
        wb_wait = 0; err_beat = 1;
        d0 = dv_cnt[0];
        push_req(0, 32'h0000_7000, 32'h0, 1'b1, 4'h0, 5'd3);
        wait_done("error", 40);
        n_cmp++; if (dv_cnt[0] - d0 != 4) begin
            n_bad++; $display("FAIL error_dv_count: got %0d expected 4", dv_cnt[0] - d0); end
        n_cmp++; if (bus_error !== 1'b1) begin
            n_bad++; $display("FAIL error_flag: got %b expected 1", bus_error); end
        err_beat = -1;
        push_req(1, 32'h0000_7100, 32'h5555_AAAA, 1'b0, 4'hC, 5'd0);
        wait_done("error_after", 40);
        n_cmp++; if (bus_error !== 1'b1) begin
            n_bad++; $display("FAIL error_sticky: got %b expected 1", bus_error); end
    endtask

    task automatic test_reset_mid_burst();
        wb_wait = 1; err_beat = -1;
        push_req(1, 32'h0000_5000, 32'h0, 1'b1, 4'h0, 5'd15);
        repeat (8) @(posedge clk);
        #2;
        n_cmp++; if (wb.cyc !== 1'b1) begin
            n_bad++; $display("FAIL mid_burst_setup: cyc=%b expected 1 before reset", wb.cyc); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({wb.cyc, wb.stb, wb.we, wb.cti, wb.sel} !== 10'b0) begin
            n_bad++; $display("FAIL async_reset_bus: cyc=%b stb=%b we=%b cti=%b sel=%h expected all 0",
                              wb.cyc, wb.stb, wb.we, wb.cti, wb.sel); end
        n_cmp++; if (bus_error !== 1'b0) begin
            n_bad++; $display("FAIL async_reset_bus_error: got %b expected 0", bus_error); end
        n_cmp++; if ({t_ack, t_dv} !== '0) begin
            n_bad++; $display("FAIL async_reset_ack_dv: ack=%b dv=%b expected 0", t_ack, t_dv); end
        clear_all();
        push_req(1, 32'h0000_6000, 32'h0, 1'b1, 4'h0, 5'd0);
        @(posedge clk);
        release_reset();
        @(negedge clk); #1;
        n_cmp++; if (t_ack !== 2'b10) begin
            n_bad++; $display("FAIL ack_first_cycle: ack=%b expected 10", t_ack); end
        wait_done("post_reset", 40);
    endtask

    initial begin
        rst_n = 1'b0;
        n_cmp = 0; n_bad = 0; cycle = 0;
        wb_ack = 1'b0; wb_err = 1'b0; wb_dat_r = '0;
        wb_wait = 0; err_beat = -1; wcnt = 0; bidx = 0;
        t_req = '0; ack_seen = '0;
        gap_due = 1'b0; prev_cyc = 1'b0;
        last_ack_cyc = 0; lat_dv = -1; lat_cyc = -1; arm_dv = 1'b0; arm_cyc = 1'b0;
        for (int i = 0; i < NP; i++) begin
            t_addr[i] = '0; t_data[i] = '0; t_rnw[i] = 1'b0; t_be[i] = '0; t_size[i] = '0;
            dv_cnt[i] = 0;
        end

        test_reset();
        test_single_read();
        test_latency();
        test_burst();
        test_write();
        test_wrap();
        test_contention();
        test_error();
        test_reset_mid_burst();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at time %0t, expected completion", $time);
        $fatal(1);
    end

endmodule
